// File: rtl/irrigation_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irrigation_pkg: phase/mode encodings shared by the irrigation     |
// | sequencer, its phase timer and the front end.                     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package irrigation_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] SPRINKLE = 3'd2;
  localparam logic [2:0] DRIP     = 3'd3;
  localparam logic [2:0] CLEAN    = 3'd4;
  localparam logic [2:0] FAULT    = 3'd5;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_SPR  = 2'b01;
  localparam logic [1:0] MODE_DRIP = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE,
    ST_FILL     = FILL,
    ST_SPRINKLE = SPRINKLE,
    ST_DRIP     = DRIP,
    ST_CLEAN    = CLEAN,
    ST_FAULT    = FAULT
  } state_e;

  // A zero duration would make a phase unreachable-by-tick; treat it as one tick.
  function automatic int eff_ticks(input int t);
    return (t == 0) ? 1 : t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_scheduler_phase_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | phase_timer: CNT_W-bit down-counter, load wins over tick; flags   |
// | time_over on a tick that finds the counter at zero.               |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             time_over
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_count_q;
  logic [CNT_W-1:0] w_count_d;
  logic             w_zero;

  // Counter holds at zero so an expired phase with no reload stays expired.
  always_comb begin
    w_zero    = (r_count_q == '0);
    w_count_d = r_count_q;
    if (load) begin
      w_count_d = load_val;
    end else if (tick && !w_zero) begin
      w_count_d = r_count_q - c_one;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= w_count_d;
    end
  end

  assign time_over = tick & w_zero;

endmodule
`default_nettype wire

// File: rtl/irrigation_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irrigation_scheduler: FILL -> SPRINKLE/DRIP -> CLEAN sequencer    |
// | with valve decode, abort handling and tank-low fault.             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int T_FILL     = 20,
  parameter int T_SPRINKLE = 30,
  parameter int T_DRIP     = 60,
  parameter int T_CLEAN    = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       abort,
  input  logic       level_low,
  input  logic       fault_clr,
  output logic [2:0] phase,
  output logic       valve_fill,
  output logic       valve_sprinkler,
  output logic       valve_drip,
  output logic       valve_drain,
  output logic       busy,
  output logic       cycle_done,
  output logic       fault
);

  localparam logic [CNT_W-1:0] c_load_fill  = CNT_W'(eff_ticks(T_FILL) - 1);
  localparam logic [CNT_W-1:0] c_load_spr   = CNT_W'(eff_ticks(T_SPRINKLE) - 1);
  localparam logic [CNT_W-1:0] c_load_drip  = CNT_W'(eff_ticks(T_DRIP) - 1);
  localparam logic [CNT_W-1:0] c_load_clean = CNT_W'(eff_ticks(T_CLEAN) - 1);

  state_e           r_state_q;
  state_e           w_state_d;
  logic [1:0]       r_mode_q;
  logic [1:0]       w_mode_d;
  logic             r_cycle_done_q;
  logic             w_cycle_done_d;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tick_act;
  logic             w_time_over;

  // The timebase only advances the timer while a timed phase is running.
  assign w_tick_act = tick & ((r_state_q == ST_FILL) || (r_state_q == ST_SPRINKLE) ||
                              (r_state_q == ST_DRIP) || (r_state_q == ST_CLEAN));

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (w_load),
    .load_val  (w_load_val),
    .tick      (w_tick_act),
    .time_over (w_time_over)
  );

  always_comb begin
    w_state_d      = r_state_q;
    w_mode_d       = r_mode_q;
    w_cycle_done_d = 1'b0;
    w_load         = 1'b0;
    w_load_val     = '0;
    case (r_state_q)
      ST_IDLE: begin
        if (req_valid && (req_mode != MODE_NONE)) begin
          w_mode_d   = req_mode;
          w_state_d  = ST_FILL;
          w_load     = 1'b1;
          w_load_val = c_load_fill;
        end
      end
      ST_FILL: begin
        if (abort) begin
          w_state_d  = ST_CLEAN;
          w_load     = 1'b1;
          w_load_val = c_load_clean;
        end else if (w_time_over) begin
          w_load = 1'b1;
          if (r_mode_q == MODE_DRIP) begin
            w_state_d  = ST_DRIP;
            w_load_val = c_load_drip;
          end else begin
            w_state_d  = ST_SPRINKLE;
            w_load_val = c_load_spr;
          end
        end
      end
      ST_SPRINKLE: begin
        if (level_low) begin
          w_state_d = ST_FAULT;
        end else if (abort) begin
          w_state_d  = ST_CLEAN;
          w_load     = 1'b1;
          w_load_val = c_load_clean;
        end else if (w_time_over) begin
          w_load = 1'b1;
          if (r_mode_q == MODE_BOTH) begin
            w_state_d  = ST_DRIP;
            w_load_val = c_load_drip;
          end else begin
            w_state_d  = ST_CLEAN;
            w_load_val = c_load_clean;
          end
        end
      end
      ST_DRIP: begin
        if (level_low) begin
          w_state_d = ST_FAULT;
        end else if (abort || w_time_over) begin
          w_state_d  = ST_CLEAN;
          w_load     = 1'b1;
          w_load_val = c_load_clean;
        end
      end
      ST_CLEAN: begin
        if (w_time_over) begin
          w_state_d      = ST_IDLE;
          w_cycle_done_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !level_low) begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q      <= ST_IDLE;
      r_mode_q       <= MODE_NONE;
      r_cycle_done_q <= 1'b0;
    end else begin
      r_state_q      <= w_state_d;
      r_mode_q       <= w_mode_d;
      r_cycle_done_q <= w_cycle_done_d;
    end
  end

  // Valves are a pure decode of the state register, so reset closes them at once.
  always_comb begin
    valve_fill      = 1'b0;
    valve_sprinkler = 1'b0;
    valve_drip      = 1'b0;
    valve_drain     = 1'b0;
    case (r_state_q)
      ST_FILL:     valve_fill      = 1'b1;
      ST_SPRINKLE: valve_sprinkler = 1'b1;
      ST_DRIP:     valve_drip      = 1'b1;
      ST_CLEAN:    valve_drain     = 1'b1;
      default:     ;
    endcase
  end

  assign phase      = r_state_q;
  assign req_ready  = (r_state_q == ST_IDLE);
  assign busy       = (r_state_q != ST_IDLE);
  assign fault      = (r_state_q == ST_FAULT);
  assign cycle_done = r_cycle_done_q;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_irrigation_scheduler: scoreboard bench with a phase-plan model |
// | of the irrigation sequencer.                                      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_irrigation_scheduler;
  import irrigation_pkg::*;

  localparam int T_F = 2;
  localparam int T_S = 3;
  localparam int T_D = 4;
  localparam int T_C = 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'b00;
  logic       abort = 1'b0;
  logic       level_low = 1'b0;
  logic       fault_clr = 1'b0;
  logic       req_ready;
  logic [2:0] phase;
  logic       valve_fill, valve_sprinkler, valve_drip, valve_drain;
  logic       busy, cycle_done, fault;

  irrigation_scheduler #(
    .CNT_W(8), .T_FILL(T_F), .T_SPRINKLE(T_S), .T_DRIP(T_D), .T_CLEAN(T_C)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req_valid(req_valid),
    .req_mode(req_mode), .req_ready(req_ready), .abort(abort), .level_low(level_low),
    .fault_clr(fault_clr), .phase(phase), .valve_fill(valve_fill),
    .valve_sprinkler(valve_sprinkler), .valve_drip(valve_drip), .valve_drain(valve_drain),
    .busy(busy), .cycle_done(cycle_done), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint t;
    int     ph;
    bit     done;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  m_phase = 0;
  int  m_left = 0;
  int  m_plan[$];
  int  exp_done_cnt = 0;
  int  got_done_cnt = 0;
  int  mon_last = 0;
  int  tick_cnt = 0;

  function automatic int dur(input int p);
    if (p == FILL) return T_F;
    if (p == SPRINKLE) return T_S;
    if (p == DRIP) return T_D;
    return T_C;
  endfunction

  // {fill, sprinkler, drip, drain}
  function automatic logic [3:0] exp_valves(input int p);
    if (p == FILL) return 4'b1000;
    if (p == SPRINKLE) return 4'b0100;
    if (p == DRIP) return 4'b0010;
    if (p == CLEAN) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic longint next_neg(input longint t);
    return (t / 10 + 1) * 10;
  endfunction

  task automatic model_set(input int p, input bit d);
    ev_t e;
    if (p != m_phase) begin
      e.t = next_neg($time);
      e.ph = p;
      e.done = d;
      exp_q.push_back(e);
      m_phase = p;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_phase(input int p, input int budget);
    int k;
    k = 0;
    while (m_phase != p && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (m_phase != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase: model phase %0d, wanted %0d within %0d cycles", m_phase, p, budget);
    end
  endtask

  task automatic send_req(input logic [1:0] m);
    @(negedge clock);
    req_valid = 1'b1;
    req_mode  = m;
    @(negedge clock);
    req_valid = 1'b0;
    req_mode  = 2'b00;
  endtask

  // Tick generator: one clock wide, every 4 clocks.
  initial forever begin
    @(negedge clock);
    tick_cnt++;
    tick = (tick_cnt % 4 == 0);
  end

  // Reference model: a phase plan plus remaining-tick count per phase.
  initial begin
    int nxt;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_plan.delete();
        m_left = 0;
        model_set(IDLE, 1'b0);
      end else if (m_phase == IDLE) begin
        if (req_valid && req_mode != 2'b00) begin
          m_plan.delete();
          if (req_mode[0]) m_plan.push_back(SPRINKLE);
          if (req_mode[1]) m_plan.push_back(DRIP);
          m_plan.push_back(CLEAN);
          m_left = T_F;
          model_set(FILL, 1'b0);
        end
      end else if (m_phase == FAULT) begin
        if (fault_clr && !level_low) model_set(IDLE, 1'b0);
      end else if (level_low && (m_phase == SPRINKLE || m_phase == DRIP)) begin
        model_set(FAULT, 1'b0);
      end else if (abort && m_phase != CLEAN) begin
        m_plan.delete();
        m_left = T_C;
        model_set(CLEAN, 1'b0);
      end else if (tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_phase == CLEAN) begin
            exp_done_cnt++;
            model_set(IDLE, 1'b1);
          end else begin
            nxt = m_plan.pop_front();
            m_left = dur(nxt);
            model_set(nxt, 1'b0);
          end
        end
      end
    end
  end

  // Monitor: every visible phase change or cycle_done pulse consumes one expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (cycle_done) got_done_cnt++;
      if (int'(phase) != mon_last || cycle_done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: phase=%0d cycle_done=%0d at t=%0t, nothing expected",
                   phase, cycle_done, $time);
        end else begin
          e = exp_q.pop_front();
          if (int'(phase) != e.ph || cycle_done !== e.done || $time != e.t ||
              {valve_fill, valve_sprinkler, valve_drip, valve_drain} !== exp_valves(e.ph) ||
              busy !== (e.ph != IDLE) || req_ready !== (e.ph == IDLE) || fault !== (e.ph == FAULT)) begin
            n_fail++;
            $display("FAIL phase_event: got phase=%0d done=%0d valves=%b busy=%0d rdy=%0d fault=%0d t=%0t; expected phase=%0d done=%0d valves=%b t=%0d",
                     phase, cycle_done, {valve_fill, valve_sprinkler, valve_drip, valve_drain},
                     busy, req_ready, fault, $time, e.ph, e.done, exp_valves(e.ph), e.t);
          end
        end
        mon_last = int'(phase);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_phase", 32'(phase), 32'(IDLE));
    check("rst_valves", 32'({valve_fill, valve_sprinkler, valve_drip, valve_drain}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cycle_done", 32'(cycle_done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    #1 reset_n = 1'b1;

    send_req(MODE_SPR);
    wait_phase(IDLE, 200);
    send_req(MODE_BOTH);
    wait_phase(IDLE, 300);

    done_before = got_done_cnt;
    send_req(MODE_NONE);
    repeat (3) @(negedge clock);
    check("none_req_ready", 32'(req_ready), 32'd1);
    check("none_phase", 32'(phase), 32'(IDLE));
    check("none_no_done", 32'(got_done_cnt), 32'(done_before));

    send_req(MODE_DRIP);
    wait_phase(DRIP, 200);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_drain", 32'(valve_drain), 32'd1);
    wait_phase(IDLE, 200);

    send_req(MODE_SPR);
    wait_phase(SPRINKLE, 200);
    level_low = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_valves", 32'({valve_fill, valve_sprinkler, valve_drip, valve_drain}), 32'd0);
    done_before = got_done_cnt;
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    @(negedge clock);
    check("fault_hold_low", 32'(phase), 32'(FAULT));
    level_low = 1'b0;
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    repeat (2) @(negedge clock);
    check("fault_exit", 32'(phase), 32'(IDLE));
    check("fault_no_done", 32'(got_done_cnt), 32'(done_before));

    send_req(MODE_SPR);
    wait_phase(SPRINKLE, 200);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valves", 32'({valve_fill, valve_sprinkler, valve_drip, valve_drain}), 32'd0);
    check("async_rst_phase", 32'(phase), 32'(IDLE));
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    send_req(MODE_SPR);
    check("post_rst_fill", 32'(phase), 32'(FILL));
    wait_phase(IDLE, 200);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      req_valid = ($urandom % 3 == 0);
      req_mode  = 2'($urandom % 4);
      abort     = ($urandom % 25 == 0);
      level_low = ($urandom % 60 == 0);
      fault_clr = ($urandom % 6 == 0);
    end
    @(negedge clock);
    req_valid = 1'b0;
    abort = 1'b0;
    level_low = 1'b0;
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    wait_phase(IDLE, 300);
    repeat (3) @(negedge clock);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(got_done_cnt), 32'(exp_done_cnt));
    check("final_phase", 32'(phase), 32'(m_phase));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
